mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between the CPU instruction-fetch port and data port.
//  Sits between the core (instrAddr / dataAddr / writeData / we) and a unified RAM.
//  Serialises accesses with a req/gnt/rvalid handshake; busy is the core stall source.
// PARAMETERS
//  ADDR_W       32  address width
//  DATA_W       32  data width
//  MEM_LATENCY  1   cycles from mem_en cycle to mem_rdata valid; legal range 1..15
// PORTS
//  clk        in   1       clock
//  n_reset    in   1       reset
//  if_req     in   1       fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W  fetch address
//  if_gnt     out  1       one-cycle pulse: fetch accepted
//  if_rvalid  out  1       one-cycle pulse: if_rdata valid
//  if_rdata   out  DATA_W  fetch data; holds last value
//  d_req      in   1       data request; held with d_we/d_addr/d_wdata until d_gnt
//  d_we       in   1       1=write, 0=read
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  write data
//  d_gnt      out  1       one-cycle pulse: data access accepted
//  d_rvalid   out  1       one-cycle pulse: read data valid / write acknowledged
//  d_rdata    out  DATA_W  read data; holds last value, unchanged by writes
//  mem_en     out  1       memory access strobe, one cycle per access
//  mem_we     out  1       memory write enable, qualified by mem_en
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LATENCY cycles after mem_en
//  busy       out  1       high whenever state != IDLE
// BEHAVIOUR
//  - Reset: n_reset synchronous, active-low; clock clk.
//  - All outputs are registered. All reset to 0. State resets to IDLE.
//  - FSM: IDLE -> ISSUE -> WAIT -> RESP -> (ISSUE | IDLE).
//  - IDLE/RESP: sample if_req and d_req.
//    - Any request present -> ISSUE next cycle; otherwise -> IDLE.
//    - Requests are ignored in ISSUE and WAIT.
//  - ISSUE (1 cycle):
//    - mem_en=1; mem_addr/mem_we/mem_wdata come from the winner (latched at the sampling edge).
//    - Winner's gnt=1. Fetch: mem_we=0, mem_wdata=0.
//  - WAIT (MEM_LATENCY cycles, down-counter):
//    - On the last WAIT cycle, capture mem_rdata into the winner's rdata register (reads only).
//  - RESP (1 cycle): winner's rvalid=1.
//  - Latency: req sampled at cycle t -> gnt at t+1 -> rvalid at t+MEM_LATENCY+2.
//  - Back-to-back throughput: one access every MEM_LATENCY+2 cycles.
//  - Requester drops or changes req the cycle after gnt. A req still high in RESP is treated as a new request.
//  - Tie (both req in the same sample cycle): d wins; if is served at the next sample (RESP of the d access).
//  - if_* and d_* pulses are never high in the same cycle.
//  - Reset mid-operation: the access is abandoned, no rvalid is issued, state returns to IDLE.
//  - MEM_LATENCY=0 is illegal: flag with an elaboration-time $error.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//    - Ties alternate via a last_grant register (reset = IF, so the first tie goes to d).
//    - Non-tie grants also update last_grant.
//  ARB_ROUND_ROBIN_EN undefined: fixed data priority, no last_grant register.
// TESTING
//  1 Reset with if_req=d_req=1: all outputs 0, busy=0, no mem_en while n_reset=0.
//  2 Fetch, MEM_LATENCY=1:
//    - if_req, if_addr=0x10 at c0 -> c1 if_gnt, mem_en=1, mem_addr=0x10.
//    - mem_rdata=0xDEADBEEF at c2 -> c3 if_rvalid=1, if_rdata=0xDEADBEEF.
//  3 Write: d_req, d_we=1, d_addr=0x100, d_wdata=0x1234 at c0
//    -> c1 mem_en=mem_we=1, mem_wdata=0x1234; c3 d_rvalid=1; d_rdata unchanged.
//  4 Tie at c0, default build:
//    - d gets gnt at c1 / rvalid at c3; if gnt at c4 / rvalid at c6.
//    - With ARB_ROUND_ROBIN_EN, repeated ties alternate d,if,d,if.
//  5 n_reset=0 during WAIT -> no rvalid; busy=0 next cycle; a fresh if_req is served normally.
//  6 MEM_LATENCY=3: read at c0 -> gnt c1, data captured at c4, rvalid c5.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port synchronous RAM between instruction-fetch and data ports.
// Optional: define ARB_ROUND_ROBIN_EN for alternating tie-breaks; default build gives data fixed priority.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("mem_arbiter: MEM_LATENCY must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    logic              r_win_d;
    logic              r_we;
    logic              r_if_gnt, r_if_rvalid, r_d_gnt, r_d_rvalid;
    logic              r_mem_en, r_mem_we, r_busy;
    logic [DATA_W-1:0] r_if_rdata, r_d_rdata, r_mem_wdata;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              w_sample, w_any, w_issue, w_last, w_pick_d;

    assign w_sample = (r_state == IDLE) || (r_state == RESP);
    assign w_any    = if_req || d_req;
    assign w_issue  = w_sample && w_any;
    assign w_last   = (r_state == WAIT) && (r_cnt == 4'd0);

`ifdef ARB_ROUND_ROBIN_EN
    // r_last_d = 1 when data won the most recent grant; reset favours data on the first tie
    logic r_last_d;
    always_ff @(posedge clk) begin
        if (!n_reset)     r_last_d <= 1'b0;
        else if (w_issue) r_last_d <= w_pick_d;
    end
    assign w_pick_d = d_req && (!if_req || !r_last_d);
`else
    assign w_pick_d = d_req;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, RESP: w_next = w_any ? ISSUE : IDLE;
            ISSUE:      w_next = WAIT;
            WAIT:       if (r_cnt == 4'd0) w_next = RESP;
            default:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_win_d     <= 1'b0;
            r_we        <= 1'b0;
            r_if_gnt    <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_busy      <= 1'b0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_mem_wdata <= '0;
            r_mem_addr  <= '0;
        end else begin
            r_state     <= w_next;
            r_busy      <= (w_next != IDLE);
            r_if_gnt    <= w_issue && !w_pick_d;
            r_d_gnt     <= w_issue && w_pick_d;
            r_mem_en    <= w_issue;
            r_if_rvalid <= w_last && !r_win_d;
            r_d_rvalid  <= w_last && r_win_d;
            // winner and its command are frozen at the sampling edge
            if (w_issue) begin
                r_win_d     <= w_pick_d;
                r_we        <= w_pick_d && d_we;
                r_mem_we    <= w_pick_d && d_we;
                r_mem_addr  <= w_pick_d ? d_addr : if_addr;
                r_mem_wdata <= w_pick_d ? d_wdata : '0;
            end else begin
                r_mem_we    <= 1'b0;
            end
            if (r_state == ISSUE)
                r_cnt <= 4'(MEM_LATENCY - 1);
            else if (r_state == WAIT && r_cnt != 4'd0)
                r_cnt <= r_cnt - 4'd1;
            if (w_last && !r_we) begin
                if (r_win_d) r_d_rdata  <= mem_rdata;
                else         r_if_rdata <= mem_rdata;
            end
        end
    end

    assign if_gnt    = r_if_gnt;
    assign if_rvalid = r_if_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_gnt     = r_d_gnt;
    assign d_rvalid  = r_d_rvalid;
    assign d_rdata   = r_d_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a MEM_LATENCY=1 instance with a RAM model, plus a MEM_LATENCY=3 instance.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // instance A, MEM_LATENCY=1
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    // instance B, MEM_LATENCY=3
    logic        b_if_req = 1'b0, b_d_req = 1'b0, b_d_we = 1'b0;
    logic [31:0] b_if_addr = '0, b_d_addr = '0, b_d_wdata = '0;
    logic        b_if_gnt, b_if_rvalid, b_d_gnt, b_d_rvalid, b_mem_en, b_mem_we, b_busy;
    logic [31:0] b_if_rdata, b_d_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .n_reset(n_reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .n_reset(n_reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    function automatic logic [31:0] init_val(input logic [9:0] a);
        return (a == 10'h010) ? 32'hDEADBEEF : (32'h5A00_0000 | {22'd0, a});
    endfunction

    // RAM model A: data valid exactly one cycle after mem_en, garbage otherwise
    logic [31:0] ram [0:1023];
    bit          ram_wr [0:1023];
    logic        rv_a = 1'b0;
    logic [31:0] rd_a = '0;
    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            ram[mem_addr[9:0]]    <= mem_wdata;
            ram_wr[mem_addr[9:0]] <= 1'b1;
        end
        rv_a <= mem_en && !mem_we;
        rd_a <= ram_wr[mem_addr[9:0]] ? ram[mem_addr[9:0]] : init_val(mem_addr[9:0]);
    end
    assign mem_rdata = rv_a ? rd_a : (32'hBAD0_0000 ^ 32'(cyc));

    // RAM model B: read-only, data valid three cycles after mem_en
    logic [2:0]  rv_b = '0;
    logic [31:0] rd_b0 = '0, rd_b1 = '0, rd_b2 = '0;
    always @(posedge clk) begin
        rv_b  <= {rv_b[1:0], b_mem_en && !b_mem_we};
        rd_b0 <= 32'hCAFE_0000 | {16'd0, b_mem_addr[15:0]};
        rd_b1 <= rd_b0;
        rd_b2 <= rd_b1;
    end
    assign b_mem_rdata = rv_b[2] ? rd_b2 : (32'hBAD1_0000 ^ 32'(cyc));

    // bench-side view of RAM contents for expected values
    logic [31:0] ref_mem [0:1023];
    bit          ref_wr  [0:1023];
    logic [31:0] exp_d_rdata = '0;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_wr[a[9:0]] ? ref_mem[a[9:0]] : init_val(a[9:0]);
    endfunction

    typedef struct {
        bit          is_d;
        logic [31:0] data;
        int          cyc;
    } sb_t;
    sb_t sb[$];

    always @(negedge clk) begin
        sb_t         e;
        logic [31:0] got;
        if (if_rvalid || d_rvalid) begin
            checks++;
            if (if_rvalid && d_rvalid) begin
                failures++;
                $display("FAIL rvalid_overlap cyc=%0d if_rvalid=1 d_rvalid=1 expected at most one", cyc);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_rvalid cyc=%0d if=%b d=%b expected none", cyc, if_rvalid, d_rvalid);
            end else begin
                e   = sb.pop_front();
                got = d_rvalid ? d_rdata : if_rdata;
                if (d_rvalid !== e.is_d || got !== e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL response got port_d=%b data=%h cyc=%0d expected port_d=%b data=%h cyc=%0d",
                             d_rvalid, got, cyc, e.is_d, e.data, e.cyc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_reset = 1'b0;
        tick();
        tick();
        n_reset = 1'b1;
        exp_d_rdata = '0;
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        if_req = 1'b1; d_req = 1'b1; b_d_req = 1'b1; b_if_req = 1'b1;
        if_addr = 32'h10; d_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if ({if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, mem_en, mem_we,
                 mem_addr, mem_wdata, busy} !== '0) begin
                failures++;
                $display("FAIL reset_a cyc=%0d mem_en=%b busy=%b if_gnt=%b d_gnt=%b expected all 0",
                         cyc, mem_en, busy, if_gnt, d_gnt);
            end
            checks++;
            if ({b_mem_en, b_busy, b_d_gnt, b_if_gnt, b_d_rvalid, b_if_rvalid} !== '0) begin
                failures++;
                $display("FAIL reset_b cyc=%0d mem_en=%b busy=%b expected 0", cyc, b_mem_en, b_busy);
            end
        end
        if_req = 1'b0; d_req = 1'b0; b_d_req = 1'b0; b_if_req = 1'b0;
        tick();
        n_reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        int c0;
        tick();
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h10;
        sb.push_back('{is_d: 1'b0, data: ref_rd(32'h10), cyc: c0 + 3});
        tick();
        checks++;
        if (!(if_gnt === 1'b1 && d_gnt === 1'b0 && mem_en === 1'b1 && mem_we === 1'b0 &&
              mem_addr === 32'h10 && mem_wdata === 32'h0 && busy === 1'b1)) begin
            failures++;
            $display("FAIL fetch_issue gnt=%b en=%b we=%b addr=%h busy=%b expected 1 1 0 00000010 1",
                     if_gnt, mem_en, mem_we, mem_addr, busy);
        end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_gnt !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL fetch_pulse gnt=%b en=%b expected 0 0", if_gnt, mem_en);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL fetch_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_write();
        int c0;
        tick();
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h1234;
        sb.push_back('{is_d: 1'b1, data: exp_d_rdata, cyc: c0 + 3});
        ref_mem[10'h100] = 32'h1234;
        ref_wr[10'h100]  = 1'b1;
        tick();
        checks++;
        if (!(d_gnt === 1'b1 && if_gnt === 1'b0 && mem_en === 1'b1 && mem_we === 1'b1 &&
              mem_addr === 32'h100 && mem_wdata === 32'h1234)) begin
            failures++;
            $display("FAIL write_issue gnt=%b en=%b we=%b addr=%h wdata=%h expected 1 1 1 00000100 00001234",
                     d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        d_req = 1'b0; d_we = 1'b0;
        tick();
        checks++;
        if (mem_en !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL write_pulse en=%b we=%b expected 0 0", mem_en, mem_we);
        end
        tick();
        tick();
        // read the written word back through the data port
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        exp_d_rdata = ref_rd(32'h100);
        sb.push_back('{is_d: 1'b1, data: exp_d_rdata, cyc: c0 + 3});
        tick();
        checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100) begin
            failures++;
            $display("FAIL readback_issue gnt=%b we=%b addr=%h expected 1 0 00000100", d_gnt, mem_we, mem_addr);
        end
        d_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_back_to_back();
        int c0;
        tick();
        c0 = cyc;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        sb.push_back('{is_d: 1'b1, data: ref_rd(32'h200), cyc: c0 + 3});
        tick();
        checks++;
        if (d_gnt !== 1'b1 || mem_addr !== 32'h200) begin
            failures++;
            $display("FAIL b2b_first gnt=%b addr=%h expected 1 00000200", d_gnt, mem_addr);
        end
        d_addr = 32'h204;
        sb.push_back('{is_d: 1'b1, data: ref_rd(32'h204), cyc: c0 + 6});
        exp_d_rdata = ref_rd(32'h204);
        tick();
        checks++;
        if (d_gnt !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL b2b_ignored gnt=%b en=%b expected 0 0", d_gnt, mem_en);
        end
        tick();
        tick();
        checks++;
        if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 32'h204) begin
            failures++;
            $display("FAIL b2b_second cyc=%0d gnt=%b en=%b addr=%h expected 1 1 00000204",
                     cyc - c0, d_gnt, mem_en, mem_addr);
        end
        d_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_tie();
        int c0;
        do_reset();
        tick();
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h20;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h30;
        sb.push_back('{is_d: 1'b1, data: ref_rd(32'h30), cyc: c0 + 3});
        sb.push_back('{is_d: 1'b0, data: ref_rd(32'h20), cyc: c0 + 6});
        exp_d_rdata = ref_rd(32'h30);
        tick();
        checks++;
        if (d_gnt !== 1'b1 || if_gnt !== 1'b0 || mem_addr !== 32'h30) begin
            failures++;
            $display("FAIL tie_d_first d_gnt=%b if_gnt=%b addr=%h expected 1 0 00000030", d_gnt, if_gnt, mem_addr);
        end
        d_req = 1'b0;
        tick();
        tick();
        tick();
        checks++;
        if (if_gnt !== 1'b1 || d_gnt !== 1'b0 || mem_addr !== 32'h20) begin
            failures++;
            $display("FAIL tie_if_second if_gnt=%b d_gnt=%b addr=%h expected 1 0 00000020", if_gnt, d_gnt, mem_addr);
        end
        if_req = 1'b0;
        repeat (3) tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL tie_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid();
        int c0;
        tick();
        if_req = 1'b1; if_addr = 32'h40;
        tick();
        checks++;
        if (if_gnt !== 1'b1) begin
            failures++;
            $display("FAIL abort_gnt gnt=%b expected 1", if_gnt);
        end
        if_req = 1'b0;
        tick();
        n_reset = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || if_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            failures++;
            $display("FAIL abort_state busy=%b rvalid=%b en=%b expected 0 0 0", busy, if_rvalid, mem_en);
        end
        n_reset = 1'b1;
        exp_d_rdata = '0;
        tick();
        c0 = cyc;
        if_req = 1'b1; if_addr = 32'h44;
        sb.push_back('{is_d: 1'b0, data: ref_rd(32'h44), cyc: c0 + 3});
        tick();
        checks++;
        if (if_gnt !== 1'b1 || mem_addr !== 32'h44) begin
            failures++;
            $display("FAIL abort_fresh gnt=%b addr=%h expected 1 00000044", if_gnt, mem_addr);
        end
        if_req = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_latency3();
        tick();
        b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h8;
        tick();
        checks++;
        if (b_d_gnt !== 1'b1 || b_mem_en !== 1'b1 || b_mem_addr !== 32'h8) begin
            failures++;
            $display("FAIL lat3_gnt gnt=%b en=%b addr=%h expected 1 1 00000008", b_d_gnt, b_mem_en, b_mem_addr);
        end
        b_d_req = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            checks++;
            if (b_d_rvalid !== 1'b0 || b_d_rdata !== 32'h0 || b_busy !== 1'b1) begin
                failures++;
                $display("FAIL lat3_wait c%0d rvalid=%b rdata=%h busy=%b expected 0 00000000 1",
                         k, b_d_rvalid, b_d_rdata, b_busy);
            end
        end
        tick();
        checks++;
        if (b_d_rvalid !== 1'b1 || b_d_rdata !== 32'hCAFE0008 || b_if_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL lat3_resp rvalid=%b rdata=%h expected 1 cafe0008", b_d_rvalid, b_d_rdata);
        end
        tick();
        checks++;
        if (b_d_rvalid !== 1'b0 || b_busy !== 1'b0 || b_d_rdata !== 32'hCAFE0008) begin
            failures++;
            $display("FAIL lat3_after rvalid=%b busy=%b rdata=%h expected 0 0 cafe0008",
                     b_d_rvalid, b_busy, b_d_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_write();
        test_back_to_back();
        test_tie();
        test_reset_mid();
        test_latency3();
        repeat (2) tick();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_rvalid pending=%0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
